// File: rtl/glue_pkg.sv
// Shared definitions for the 68000 bus glue (DTACK/BERR generation).
//   state_t       : bus-cycle FSM encoding (IDLE=0, WAIT=1, ACK=2, BERR=3)
//   WAIT_W        : width of one per-region wait-state field
//   NUM_REGIONS   : number of chip-select regions
//   first_low_idx : lowest index of a low bit in an active-low select vector
package glue_pkg;

  localparam int WAIT_W      = 4;
  localparam int NUM_REGIONS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } state_t;

  // Priority encoder: scan from the top down so the lowest low bit wins.
  function automatic logic [2:0] first_low_idx(input logic [NUM_REGIONS-1:0] sel_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (!sel_n[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/glue_down_counter.sv
// Loadable down-counter used for the wait-state countdown.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over en)
//   load_val : value to load
//   en       : decrement by one; holds at zero
//   count    : current count
//   zero     : count == 0
module glue_down_counter
  import glue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              en,
  output logic [WAIT_W-1:0] count,
  output logic              zero
);

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (en && !zero)   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dtack_generator.sv
// DTACK/BERR generator for a 68000 bus with eight decoded chip-select regions.
// Each region has its own wait-state count; the acknowledge is a registered
// active-low strobe held until the CPU releases AS.
//
// Optional feature (macro DTACK_GENERATOR_WATCHDOG_EN): a bus watchdog that
// raises BERR when a strobe stays unacknowledged for TIMEOUT_CYCLES clocks.
// Without it berr_n is tied high and unselected cycles hang.
//
// Parameters:
//   WAIT_STATES    : packed 8x4-bit wait counts, bits [4k+3:4k] for cs_n[k]
//   TIMEOUT_CYCLES : watchdog limit in clk cycles (2..255)
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   as_n    : address strobe, active low, synchronous to clk
//   cs_n    : active-low one-hot chip selects
//   dtack_n : registered data-transfer acknowledge, active low
//   berr_n  : registered bus error, active low
//   region  : region being served (valid while busy)
//   busy    : FSM not in IDLE
module dtack_generator
  import glue_pkg::*;
#(
  parameter logic [31:0] WAIT_STATES    = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       as_n,
  input  logic [7:0] cs_n,
  output logic       dtack_n,
  output logic       berr_n,
  output logic [2:0] region,
  output logic       busy
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dtack_generator: TIMEOUT_CYCLES out of range 2..255");
  end

  state_t            state, state_next;
  logic [2:0]        region_q;
  logic [2:0]        sel_idx;
  logic              sel_any;
  logic              start;
  logic [WAIT_W-1:0] load_val;
  logic [WAIT_W-1:0] cnt;
  logic              cnt_zero;
  logic              wait_last;

  assign sel_idx  = first_low_idx(cs_n);
  assign sel_any  = (cs_n != 8'hFF);
  assign start    = (state == ST_IDLE) && !as_n && sel_any;
  assign load_val = WAIT_STATES[sel_idx*WAIT_W +: WAIT_W];

  // The counter holds N at the edge after the latch; ACK must be entered on
  // the edge where it steps 1->0 so dtack_n lands exactly N+1 edges later.
  assign wait_last = (cnt == WAIT_W'(1)) || cnt_zero;

  glue_down_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (load_val),
    .en       (state == ST_WAIT),
    .count    (cnt),
    .zero     (cnt_zero)
  );

`ifdef DTACK_GENERATOR_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wd_cnt;
  logic       wd_fire;

  // Counts strobe-low cycles with no acknowledge; saturates at the limit so
  // it cannot wrap while the FSM is on its way into BERR.
  always_ff @(posedge clk) begin
    if (rst || as_n)
      wd_cnt <= '0;
    else if (dtack_n && state != ST_BERR && wd_cnt != WD_LIMIT)
      wd_cnt <= wd_cnt + 8'd1;
  end

  assign wd_fire = !as_n && (wd_cnt == WD_LIMIT);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (load_val == '0) ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        if (as_n)           state_next = ST_IDLE;
        else if (wait_last) state_next = ST_ACK;
      end
      ST_ACK:  if (as_n) state_next = ST_IDLE;
      ST_BERR: if (as_n) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
`ifdef DTACK_GENERATOR_WATCHDOG_EN
    // Watchdog pre-empts a pending or stalled cycle, never an acknowledge.
    if (wd_fire && (state == ST_IDLE || state == ST_WAIT))
      state_next = ST_BERR;
`endif
  end

  // Strobes go low one edge after the state is entered and release on the
  // same edge the FSM leaves, so they can never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      dtack_n  <= 1'b1;
      region_q <= '0;
    end else begin
      dtack_n <= !(state == ST_ACK && state_next == ST_ACK);
      if (start) region_q <= sel_idx;
    end
  end

`ifdef DTACK_GENERATOR_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) berr_n <= 1'b1;
    else     berr_n <= !(state == ST_BERR && state_next == ST_BERR);
  end
`else
  assign berr_n = 1'b1;
`endif

  assign region = region_q;
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_dtack_generator.sv
// Directed bench for dtack_generator. Region waits: r0=0 r1=2 r2=5 r3=7 r5=3.
module tb_dtack_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       as_n;
  logic [7:0] cs_n;
  logic       dtack_n;
  logic       berr_n;
  logic [2:0] region;
  logic       busy;

  int checks = 0;
  int errors = 0;

  dtack_generator #(
    .WAIT_STATES    (32'h0030_7520),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .as_n    (as_n),
    .cs_n    (cs_n),
    .dtack_n (dtack_n),
    .berr_n  (berr_n),
    .region  (region),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    as_n = 1'b1;
    cs_n = 8'hFF;
    step();
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: dtack_n=%b busy=%b, want dtack_n=1 busy=0", dtack_n, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; as_n = 1'b0; cs_n = 8'hFE;
    repeat (3) begin
      step();
      checks++;
      if (dtack_n !== 1'b1 || berr_n !== 1'b1 || busy !== 1'b0 || region !== 3'd0) begin
        errors++;
        $display("FAIL reset: dtack_n=%b berr_n=%b busy=%b region=%0d, want 1 1 0 0",
                 dtack_n, berr_n, busy, region);
      end
    end
    as_n = 1'b1; cs_n = 8'hFF;
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    as_n = 1'b0; cs_n = 8'hFE;
    step();  // edge T
    checks++;
    if (busy !== 1'b1 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL zw_T: busy=%b dtack_n=%b, want 1 1", busy, dtack_n);
    end
    step();  // T+1
    checks++;
    if (dtack_n !== 1'b0 || region !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zw_ack: dtack_n=%b region=%0d busy=%b, want 0 0 1", dtack_n, region, busy);
    end
    step();  // still held
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL zw_hold: dtack_n=%b, want 0", dtack_n);
    end
    release_bus();
  endtask

  task automatic test_wait3();
    as_n = 1'b0; cs_n = 8'hDF;
    step();  // T
    cs_n = 8'hFE;  // later selects must be ignored
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin
        errors++;
        $display("FAIL w3_early T+%0d: dtack_n=%b berr_n=%b, want 1 1", i, dtack_n, berr_n);
      end
    end
    step();  // T+4
    checks++;
    if (dtack_n !== 1'b0 || region !== 3'd5) begin
      errors++;
      $display("FAIL w3_ack: dtack_n=%b region=%0d, want 0 5", dtack_n, region);
    end
    release_bus();
  endtask

  task automatic test_abort();
    as_n = 1'b0; cs_n = 8'hFB;
    step();  // T
    step();  // T+1
    step();  // T+2
    checks++;
    if (busy !== 1'b1 || region !== 3'd2) begin
      errors++;
      $display("FAIL ab_wait: busy=%b region=%0d, want 1 2", busy, region);
    end
    as_n = 1'b1; cs_n = 8'hFF;
    step();  // T+3
    checks++;
    if (busy !== 1'b0 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL ab_idle: busy=%b dtack_n=%b, want 0 1", busy, dtack_n);
    end
    repeat (6) begin
      step();
      checks++;
      if (dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL ab_nopulse: dtack_n=%b, want 1", dtack_n);
      end
    end
  endtask

  task automatic test_priority();
    as_n = 1'b0; cs_n = 8'hF5;
    step();  // T
    step();  // T+1
    step();  // T+2
    checks++;
    if (dtack_n !== 1'b1 || region !== 3'd1) begin
      errors++;
      $display("FAIL pri_wait: dtack_n=%b region=%0d, want 1 1", dtack_n, region);
    end
    step();  // T+3
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL pri_ack: dtack_n=%b, want 0", dtack_n);
    end
    release_bus();
  endtask

  task automatic test_back_to_back();
    as_n = 1'b0; cs_n = 8'hFE;
    step(); step();
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: dtack_n=%b, want 0", dtack_n);
    end
    release_bus();
    as_n = 1'b0; cs_n = 8'hF7;
    step();  // T, region 3 wait 7
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++;
      if (dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL b2b_early T+%0d: dtack_n=%b, want 1", i, dtack_n);
      end
    end
    step();  // T+8
    checks++;
    if (dtack_n !== 1'b0 || region !== 3'd3) begin
      errors++;
      $display("FAIL b2b_ack: dtack_n=%b region=%0d, want 0 3", dtack_n, region);
    end
    release_bus();
  endtask

  task automatic test_unselected();
    as_n = 1'b0; cs_n = 8'hFF;
`ifdef DTACK_GENERATOR_WATCHDOG_EN
    step();  // T, watchdog count 1
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (berr_n !== 1'b1 || dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL wd_early T+%0d: berr_n=%b dtack_n=%b, want 1 1", i, berr_n, dtack_n);
      end
    end
    step();  // T+17
    checks++;
    if (berr_n !== 1'b0 || dtack_n !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_berr: berr_n=%b dtack_n=%b busy=%b, want 0 1 1", berr_n, dtack_n, busy);
    end
    step();
    checks++;
    if (berr_n !== 1'b0 || dtack_n !== 1'b1) begin
      errors++;
      $display("FAIL wd_hold: berr_n=%b dtack_n=%b, want 0 1", berr_n, dtack_n);
    end
    as_n = 1'b1;
    step();
    checks++;
    if (berr_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_release: berr_n=%b busy=%b, want 1 0", berr_n, busy);
    end
`else
    repeat (40) begin
      step();
      checks++;
      if (berr_n !== 1'b1 || dtack_n !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL hang: berr_n=%b dtack_n=%b busy=%b, want 1 1 0", berr_n, dtack_n, busy);
      end
    end
    as_n = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_in_ack();
    as_n = 1'b0; cs_n = 8'hFE;
    step(); step();
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL rack_pre: dtack_n=%b, want 0", dtack_n);
    end
    rst = 1'b1;
    step();
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0 || region !== 3'd0) begin
      errors++;
      $display("FAIL rack: dtack_n=%b busy=%b region=%0d, want 1 0 0", dtack_n, busy, region);
    end
    rst = 1'b0; as_n = 1'b1; cs_n = 8'hFF;
    step();
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rack_post: dtack_n=%b busy=%b, want 1 0", dtack_n, busy);
    end
  endtask

  initial begin
    rst = 1'b1; as_n = 1'b1; cs_n = 8'hFF;
    test_reset();
    test_zero_wait();
    test_wait3();
    test_abort();
    test_priority();
    test_back_to_back();
    test_unselected();
    test_reset_in_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
